// File: rtl/wdt_timer_pkg.sv
// rtl/wdt_timer_pkg.sv - shared widths, state encodings and load clamp for the watchdog
package wdt_timer_pkg;

    localparam int CNT_W   = 16;
    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        WDT_IDLE = 2'b00,
        WDT_RUN  = 2'b01,
        WDT_WARN = 2'b10,
        WDT_BITE = 2'b11
    } wdt_state_t;

    // A zero timeout would expire before it could ever be serviced, so it runs as one tick.
    function automatic logic [CNT_W-1:0] clamp_load(input logic [CNT_W-1:0] value);
        return (value == '0) ? CNT_W'(1) : value;
    endfunction

endpackage

// File: rtl/wdt_timer_if.sv
// rtl/wdt_timer_if.sv - watchdog control/status bundle; wdt_win exists only with WDT_WINDOW_EN
interface wdt_timer_if;
    import wdt_timer_pkg::*;

    logic                 wdt_en;
    logic [CNT_W-1:0]     wdt_load;
    logic                 wdt_kick;
`ifdef WDT_WINDOW_EN
    logic [CNT_W-1:0]     wdt_win;
`endif
    logic [CNT_W-1:0]     wdt_cnt;
    logic [STATE_W-1:0]   wdt_state;
    logic                 wdt_irq;
    logic                 wdt_rst_req;

    modport master (
`ifdef WDT_WINDOW_EN
        output wdt_win,
`endif
        output wdt_en, wdt_load, wdt_kick,
        input  wdt_cnt, wdt_state, wdt_irq, wdt_rst_req
    );

    modport slave (
`ifdef WDT_WINDOW_EN
        input  wdt_win,
`endif
        input  wdt_en, wdt_load, wdt_kick,
        output wdt_cnt, wdt_state, wdt_irq, wdt_rst_req
    );

endinterface

// File: rtl/wdt_tick_det.sv
// rtl/wdt_tick_det.sv - one-clk tick on each rising edge of clk_20k
module wdt_tick_det (
    input  logic clk,
    input  logic rst,
    input  logic clk_20k,
    output logic tick
);

    logic clk_20k_d;
    logic armed;

    // armed keeps a clk_20k that is already high when reset lifts from looking like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_20k_d <= 1'b0;
            armed     <= 1'b0;
        end else begin
            clk_20k_d <= clk_20k;
            armed     <= 1'b1;
        end
    end

    assign tick = clk_20k & ~clk_20k_d & armed;

endmodule

// File: rtl/wdt_timer.sv
// rtl/wdt_timer.sv - watchdog: timeout, warning irq, fixed-length reset request; WDT_WINDOW_EN adds early-kick window
module wdt_timer
    import wdt_timer_pkg::*;
#(
    parameter int WARN_TICKS = 64,
    parameter int RST_CYCLES = 32
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clk_20k,
    wdt_timer_if.slave bus
);

    localparam int PULSE_W = $clog2(RST_CYCLES + 1);

    wdt_state_t         state, state_nxt;
    logic [CNT_W-1:0]   cnt, cnt_nxt;
    logic [PULSE_W-1:0] pulse, pulse_nxt;
    logic               irq, irq_nxt;
    logic               rst_req, rst_req_nxt;
    logic               tick;
    logic               expire;
    logic               early_kick;
    logic [CNT_W-1:0]   reload;

    wdt_tick_det u_tick_det (
        .clk     (clk),
        .rst     (rst),
        .clk_20k (clk_20k),
        .tick    (tick)
    );

    assign reload = clamp_load(bus.wdt_load);
    assign expire = tick && (cnt == CNT_W'(1));

`ifdef WDT_WINDOW_EN
    assign early_kick = bus.wdt_kick && (state == WDT_RUN) && (cnt > bus.wdt_win);
`else
    assign early_kick = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= WDT_IDLE;
            cnt     <= '0;
            pulse   <= '0;
            irq     <= 1'b0;
            rst_req <= 1'b0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pulse   <= pulse_nxt;
            irq     <= irq_nxt;
            rst_req <= rst_req_nxt;
        end
    end

    // Priority in RUN/WARN: disable, then kick (early or normal), then tick expiry.
    always_comb begin
        state_nxt = state;
        case (state)
            WDT_IDLE: if (bus.wdt_en) state_nxt = WDT_RUN;
            WDT_RUN, WDT_WARN: begin
                if (!bus.wdt_en)       state_nxt = WDT_IDLE;
                else if (early_kick)   state_nxt = WDT_BITE;
                else if (bus.wdt_kick) state_nxt = WDT_RUN;
                else if (expire)       state_nxt = (state == WDT_RUN) ? WDT_WARN : WDT_BITE;
            end
            WDT_BITE: if (pulse == PULSE_W'(1)) state_nxt = WDT_IDLE;
            default:  state_nxt = WDT_IDLE;
        endcase
    end

    always_comb begin
        cnt_nxt     = cnt;
        pulse_nxt   = pulse;
        irq_nxt     = irq;
        rst_req_nxt = rst_req;
        if (state_nxt == WDT_IDLE) begin
            cnt_nxt     = '0;
            pulse_nxt   = '0;
            irq_nxt     = 1'b0;
            rst_req_nxt = 1'b0;
        end else if (state_nxt == WDT_BITE) begin
            cnt_nxt     = '0;
            rst_req_nxt = 1'b1;
            pulse_nxt   = (state == WDT_BITE) ? pulse - PULSE_W'(1) : PULSE_W'(RST_CYCLES);
        end else if (state_nxt == WDT_WARN && state == WDT_RUN) begin
            cnt_nxt = CNT_W'(WARN_TICKS);
            irq_nxt = 1'b1;
        end else if (state == WDT_IDLE || bus.wdt_kick) begin
            cnt_nxt = reload;
            irq_nxt = 1'b0;
        end else if (tick && cnt != '0) begin
            cnt_nxt = cnt - CNT_W'(1);
        end
    end

    assign bus.wdt_cnt     = cnt;
    assign bus.wdt_state   = state;
    assign bus.wdt_irq     = irq;
    assign bus.wdt_rst_req = rst_req;

endmodule

// File: tb/tb_wdt_timer.sv
// tb/tb_wdt_timer.sv - directed scenarios plus randomized run against a behavioural watchdog model
module tb_wdt_timer;

    localparam int WARN = 64;
    localparam int RSTC = 32;
    localparam int TP   = 16;
    localparam int S_IDLE = 0, S_RUN = 1, S_WARN = 2, S_BITE = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_20k = 1'b0;
    int   div = 0;
    int   checks = 0;
    int   failures = 0;

    wdt_timer_if bus ();

    wdt_timer #(.WARN_TICKS(WARN), .RST_CYCLES(RSTC)) dut (
        .clk     (clk),
        .rst     (rst),
        .clk_20k (clk_20k),
        .bus     (bus)
    );

    always #5 clk = ~clk;

    // Slow clock kept much faster than 1024 clk so the long scenarios stay short.
    always @(posedge clk) begin
        div     <= (div == TP - 1) ? 0 : div + 1;
        clk_20k <= (div < TP / 2);
    end

    int m_state, m_cnt, m_pulse;
    bit m_irq, m_rst, m_prev, m_armed;

    function automatic bit tick_pending();
        return clk_20k && !m_prev && m_armed;
    endfunction

    function automatic int load_of(input logic [15:0] v);
        return (v == 0) ? 1 : int'(v);
    endfunction

    function automatic bit early_kick();
`ifdef WDT_WINDOW_EN
        return (m_state == S_RUN) && (m_cnt > int'(bus.wdt_win));
`else
        return 1'b0;
`endif
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_state <= S_IDLE; m_cnt <= 0; m_pulse <= 0;
            m_irq <= 1'b0; m_rst <= 1'b0; m_prev <= 1'b0; m_armed <= 1'b0;
        end else begin
            m_prev  <= clk_20k;
            m_armed <= 1'b1;
            if (m_state == S_BITE) begin
                if (m_pulse == 1) begin
                    m_state <= S_IDLE; m_rst <= 1'b0; m_irq <= 1'b0;
                end
                m_pulse <= m_pulse - 1;
            end else if (!bus.wdt_en) begin
                m_state <= S_IDLE; m_cnt <= 0; m_irq <= 1'b0;
            end else if (m_state == S_IDLE) begin
                m_state <= S_RUN; m_cnt <= load_of(bus.wdt_load);
            end else if (bus.wdt_kick && early_kick()) begin
                m_state <= S_BITE; m_cnt <= 0; m_rst <= 1'b1; m_pulse <= RSTC;
            end else if (bus.wdt_kick) begin
                m_state <= S_RUN; m_cnt <= load_of(bus.wdt_load); m_irq <= 1'b0;
            end else if (tick_pending()) begin
                if (m_cnt == 1 && m_state == S_RUN) begin
                    m_state <= S_WARN; m_irq <= 1'b1; m_cnt <= WARN;
                end else if (m_cnt == 1) begin
                    m_state <= S_BITE; m_cnt <= 0; m_rst <= 1'b1; m_pulse <= RSTC;
                end else if (m_cnt > 1) begin
                    m_cnt <= m_cnt - 1;
                end
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wdt_en = 1'b0;
        bus.wdt_kick = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.wdt_en = 1'b1;
        @(negedge clk);
        checks++; if (bus.wdt_state !== 2'd0) begin failures++; $display("FAIL reset_state got=%0d exp=0", bus.wdt_state); end
        checks++; if (bus.wdt_cnt !== 16'd0) begin failures++; $display("FAIL reset_cnt got=%0d exp=0", bus.wdt_cnt); end
        checks++; if (bus.wdt_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", bus.wdt_irq); end
        checks++; if (bus.wdt_rst_req !== 1'b0) begin failures++; $display("FAIL reset_rst_req got=%b exp=0", bus.wdt_rst_req); end
        bus.wdt_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_timeout();
        int n, ticks, hi;
        do_reset();
        bus.wdt_load = 16'd3;
        bus.wdt_en = 1'b1;
        n = 0;
        while (bus.wdt_state !== 2'd1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (bus.wdt_cnt !== 16'd3) begin failures++; $display("FAIL t1_load_cnt got=%0d exp=3", bus.wdt_cnt); end
        ticks = 0; n = 0;
        while (bus.wdt_irq !== 1'b1 && n < 2000) begin
            if (tick_pending()) ticks++;
            @(negedge clk); n++;
        end
        checks++; if (ticks != 3) begin failures++; $display("FAIL t1_irq_tick got=%0d exp=3", ticks); end
        checks++; if (bus.wdt_state !== 2'd2 || bus.wdt_cnt !== 16'(WARN)) begin
            failures++; $display("FAIL t1_warn got=%0d/%0d exp=2/%0d", bus.wdt_state, bus.wdt_cnt, WARN); end
        ticks = 0; n = 0;
        while (bus.wdt_rst_req !== 1'b1 && n < 4000) begin
            if (tick_pending()) ticks++;
            @(negedge clk); n++;
        end
        checks++; if (ticks != WARN) begin failures++; $display("FAIL t1_bite_tick got=%0d exp=%0d", ticks, WARN); end
        hi = 0;
        while (bus.wdt_rst_req === 1'b1 && hi < 200) begin @(negedge clk); hi++; end
        checks++; if (hi != RSTC) begin failures++; $display("FAIL t1_rst_len got=%0d exp=%0d", hi, RSTC); end
        checks++; if (bus.wdt_state !== 2'd0 || bus.wdt_irq !== 1'b0) begin
            failures++; $display("FAIL t1_idle got=%0d/%b exp=0/0", bus.wdt_state, bus.wdt_irq); end
        @(negedge clk);
        checks++; if (bus.wdt_state !== 2'd1 || bus.wdt_cnt !== 16'd3) begin
            failures++; $display("FAIL t1_rerun got=%0d/%0d exp=1/3", bus.wdt_state, bus.wdt_cnt); end
    endtask

    task automatic test_kick_service();
        int n, ticks, last;
        bit irq_seen;
        do_reset();
        bus.wdt_load = 16'd5;
        bus.wdt_en = 1'b1;
        n = 0;
        while (bus.wdt_state !== 2'd1 && n < 50) begin @(negedge clk); n++; end
        ticks = 0; last = 0; irq_seen = 1'b0; n = 0;
        while (ticks < 20 && n < 2000) begin
            if (tick_pending()) ticks++;
            @(negedge clk); n++;
            if (bus.wdt_irq) irq_seen = 1'b1;
            if (ticks % 4 == 0 && ticks != last) begin
                last = ticks;
                bus.wdt_kick = 1'b1;
                @(negedge clk); n++;
                bus.wdt_kick = 1'b0;
                checks++; if (bus.wdt_cnt !== 16'd5) begin failures++; $display("FAIL t2_reload tick=%0d got=%0d exp=5", ticks, bus.wdt_cnt); end
            end
        end
        checks++; if (irq_seen || ticks != 20) begin failures++; $display("FAIL t2_no_irq irq=%b ticks=%0d exp=0/20", irq_seen, ticks); end
    endtask

    task automatic test_kick_tick_same();
        int n;
        do_reset();
        bus.wdt_load = 16'd5;
        bus.wdt_en = 1'b1;
        n = 0;
        while (!(bus.wdt_state === 2'd1 && bus.wdt_cnt === 16'd1) && n < 2000) begin @(negedge clk); n++; end
        while (!tick_pending() && n < 2000) begin @(negedge clk); n++; end
        checks++; if (n >= 2000) begin failures++; $display("FAIL t3_wait timeout got=%0d exp<2000", n); end
        bus.wdt_kick = 1'b1;
        @(negedge clk);
        bus.wdt_kick = 1'b0;
        checks++; if (bus.wdt_cnt !== 16'd5 || bus.wdt_state !== 2'd1 || bus.wdt_irq !== 1'b0) begin
            failures++; $display("FAIL t3_kick_wins got=%0d/%0d/%b exp=5/1/0", bus.wdt_cnt, bus.wdt_state, bus.wdt_irq); end
    endtask

    task automatic test_disable_warn();
        int n;
        do_reset();
        bus.wdt_load = 16'd2;
        bus.wdt_en = 1'b1;
        n = 0;
        while (!(bus.wdt_state === 2'd2 && bus.wdt_cnt === 16'd10) && n < 3000) begin @(negedge clk); n++; end
        checks++; if (n >= 3000) begin failures++; $display("FAIL t4_wait timeout got=%0d exp<3000", n); end
        bus.wdt_en = 1'b0;
        @(negedge clk);
        checks++; if (bus.wdt_state !== 2'd0 || bus.wdt_cnt !== 16'd0 || bus.wdt_irq !== 1'b0 || bus.wdt_rst_req !== 1'b0) begin
            failures++; $display("FAIL t4_disable got=%0d/%0d/%b/%b exp=0/0/0/0", bus.wdt_state, bus.wdt_cnt, bus.wdt_irq, bus.wdt_rst_req); end
    endtask

    task automatic test_load_zero_abort();
        int n, ticks;
        do_reset();
        bus.wdt_load = 16'd0;
        bus.wdt_en = 1'b1;
        n = 0;
        while (bus.wdt_state !== 2'd1 && n < 50) begin @(negedge clk); n++; end
        checks++; if (bus.wdt_cnt !== 16'd1) begin failures++; $display("FAIL t5_clamp got=%0d exp=1", bus.wdt_cnt); end
        ticks = 0; n = 0;
        while (bus.wdt_irq !== 1'b1 && n < 500) begin
            if (tick_pending()) ticks++;
            @(negedge clk); n++;
        end
        checks++; if (ticks != 1) begin failures++; $display("FAIL t5_irq_tick got=%0d exp=1", ticks); end
        n = 0;
        while (bus.wdt_state !== 2'd3 && n < 4000) begin @(negedge clk); n++; end
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.wdt_rst_req !== 1'b0 || bus.wdt_state !== 2'd0) begin
            failures++; $display("FAIL t5_abort got=%b/%0d exp=0/0", bus.wdt_rst_req, bus.wdt_state); end
        @(negedge clk);
        bus.wdt_en = 1'b0;
        rst = 1'b0;
    endtask

`ifdef WDT_WINDOW_EN
    task automatic test_window();
        int n;
        do_reset();
        bus.wdt_load = 16'd10;
        bus.wdt_win = 16'd4;
        bus.wdt_en = 1'b1;
        n = 0;
        while (!(bus.wdt_state === 2'd1 && bus.wdt_cnt === 16'd7 && !tick_pending()) && n < 1000) begin @(negedge clk); n++; end
        bus.wdt_kick = 1'b1;
        @(negedge clk);
        bus.wdt_kick = 1'b0;
        checks++; if (bus.wdt_state !== 2'd3 || bus.wdt_irq !== 1'b0 || bus.wdt_rst_req !== 1'b1) begin
            failures++; $display("FAIL t6_early got=%0d/%b/%b exp=3/0/1", bus.wdt_state, bus.wdt_irq, bus.wdt_rst_req); end
        do_reset();
        bus.wdt_en = 1'b1;
        n = 0;
        while (!(bus.wdt_state === 2'd1 && bus.wdt_cnt === 16'd4 && !tick_pending()) && n < 1000) begin @(negedge clk); n++; end
        bus.wdt_kick = 1'b1;
        @(negedge clk);
        bus.wdt_kick = 1'b0;
        checks++; if (bus.wdt_state !== 2'd1 || bus.wdt_cnt !== 16'd10) begin
            failures++; $display("FAIL t6_in_window got=%0d/%0d exp=1/10", bus.wdt_state, bus.wdt_cnt); end
    endtask
`endif

    task automatic test_random();
        int kick_div;
        do_reset();
        for (int seg = 0; seg < 8; seg++) begin
            case (seg % 4)
                0: kick_div = 0;
                1: kick_div = 20;
                2: kick_div = 300;
                default: kick_div = 60;
            endcase
            for (int c = 0; c < 500; c++) begin
                @(negedge clk);
                checks++;
                if (bus.wdt_state !== 2'(m_state) || bus.wdt_cnt !== 16'(m_cnt) ||
                    bus.wdt_irq !== m_irq || bus.wdt_rst_req !== m_rst) begin
                    failures++;
                    $display("FAIL rand seg=%0d c=%0d got st=%0d cnt=%0d irq=%b rq=%b exp st=%0d cnt=%0d irq=%b rq=%b",
                             seg, c, bus.wdt_state, bus.wdt_cnt, bus.wdt_irq, bus.wdt_rst_req,
                             m_state, m_cnt, m_irq, m_rst);
                end
                bus.wdt_en   = ($urandom_range(0, 199) != 0);
                bus.wdt_kick = (kick_div != 0) && ($urandom_range(0, kick_div - 1) == 0);
                if ($urandom_range(0, 15) == 0) bus.wdt_load = 16'($urandom_range(0, 6));
`ifdef WDT_WINDOW_EN
                if ($urandom_range(0, 15) == 0) bus.wdt_win = 16'($urandom_range(0, 6));
`endif
                if ($urandom_range(0, 999) == 0) begin
                    @(posedge clk);
                    #2 rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                end
            end
        end
    endtask

    initial begin
        bus.wdt_en = 1'b0;
        bus.wdt_kick = 1'b0;
        bus.wdt_load = 16'd0;
`ifdef WDT_WINDOW_EN
        bus.wdt_win = 16'hFFFF;
`endif
        test_reset();
        test_timeout();
        test_kick_service();
        test_kick_tick_same();
        test_disable_warn();
        test_load_zero_abort();
`ifdef WDT_WINDOW_EN
        test_window();
        bus.wdt_win = 16'hFFFF;
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
